// File: rtl/bram_arb_pkg.sv
// Shared types and constants for the two-port BRAM arbiter.
// Build option: BRAM_ARB_RR_EN selects round-robin contention (tested only in bram_arb_pick).
package bram_arb_pkg;

  // Arbiter states: normal arbitration, DMA burst lock, one forced CPU slot.
  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_LOCK1 = 2'd1,
    ST_YIELD = 2'd2
  } arb_state_e;

  // Requester port indices, used for the read-return tag.
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  // Width of the consecutive-locked-grant counter (MAX_LOCK fits in 1..255).
  localparam int LOCK_CNT_W = 8;

endpackage

// File: rtl/bram_arb_pick.sv
// Combinational winner selection for the BRAM arbiter.
// Build option: BRAM_ARB_RR_EN -- defined: round-robin on contention in ST_ARB;
// undefined: fixed priority, CPU port wins contention.
module bram_arb_pick
  import bram_arb_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  arb_state_e state,
  input  logic       rr_last,  // 1 when the CPU port took the most recent grant
  output logic       gnt0,
  output logic       gnt1
);

  logic contend_to_dma;

`ifdef BRAM_ARB_RR_EN
  // The port that did not take the last grant wins a tie.
  assign contend_to_dma = rr_last;
`else
  logic unused_rr_last;
  assign contend_to_dma = 1'b0;
  assign unused_rr_last = rr_last;
`endif

  // Pick the winner for this cycle from the state and the live requests.
  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case (state)
      ST_LOCK1: gnt1 = req1;
      ST_YIELD: gnt0 = req0;
      default: begin
        if (req0 && req1) begin
          gnt1 = contend_to_dma;
          gnt0 = ~contend_to_dma;
        end else begin
          gnt0 = req0;
          gnt1 = req1;
        end
      end
    endcase
  end

endmodule

// File: rtl/bram_arbiter.sv
// Two-port arbiter sharing a single-port synchronous BRAM between the CPU
// path (port 0) and the DMA engine (port 1), with a bounded DMA burst lock
// and a read tag that routes each 1-cycle-latency read result home.
// Build option: BRAM_ARB_RR_EN (see bram_arb_pick).
module bram_arbiter
  import bram_arb_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int MAX_LOCK = 160
) (
  input  logic              I_CLK,
  input  logic              I_RESET_L,
  input  logic              I_REQ0,
  input  logic              I_REQ1,
  input  logic              I_WE0,
  input  logic              I_WE1,
  input  logic [ADDR_W-1:0] I_ADDR0,
  input  logic [ADDR_W-1:0] I_ADDR1,
  input  logic [DATA_W-1:0] I_DATA0,
  input  logic [DATA_W-1:0] I_DATA1,
  input  logic              I_LOCK1,
  output logic              O_ACK0,
  output logic              O_ACK1,
  output logic              O_RVALID0,
  output logic              O_RVALID1,
  output logic [DATA_W-1:0] O_DATA0,
  output logic [DATA_W-1:0] O_DATA1,
  output logic              O_BRAM_EN,
  output logic              O_BRAM_WE,
  output logic [ADDR_W-1:0] O_BRAM_ADDR,
  output logic [DATA_W-1:0] O_BRAM_DIN,
  input  logic [DATA_W-1:0] I_BRAM_DOUT
);

  localparam logic [LOCK_CNT_W-1:0] LOCK_MAX = LOCK_CNT_W'(MAX_LOCK);
  localparam logic [LOCK_CNT_W-1:0] LOCK_ONE = LOCK_CNT_W'(1);

  arb_state_e            state_q, state_d;
  logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d, lock_inc;
  logic                  rr_last_q, rr_last_d;
  logic                  tag_valid_q, tag_port_q;
  logic [DATA_W-1:0]     hold0_q, hold1_q;
  logic                  pick0, pick1, gnt0, gnt1, gnt_any;

  bram_arb_pick u_pick (
    .req0    (I_REQ0),
    .req1    (I_REQ1),
    .state   (state_q),
    .rr_last (rr_last_q),
    .gnt0    (pick0),
    .gnt1    (pick1)
  );

  // No grant is ever made while reset is asserted.
  assign gnt0    = pick0 & I_RESET_L;
  assign gnt1    = pick1 & I_RESET_L;
  assign gnt_any = gnt0 | gnt1;
  assign O_ACK0  = gnt0;
  assign O_ACK1  = gnt1;

  // Saturating increment so the lock counter can never wrap.
  assign lock_inc = (lock_cnt_q == LOCK_MAX) ? LOCK_MAX : lock_cnt_q + LOCK_ONE;

  // Drive the BRAM from the granted port; park address/data at 0 when idle.
  always_comb begin
    O_BRAM_EN   = gnt_any;
    O_BRAM_WE   = 1'b0;
    O_BRAM_ADDR = '0;
    O_BRAM_DIN  = '0;
    if (gnt0) begin
      O_BRAM_WE   = I_WE0;
      O_BRAM_ADDR = I_ADDR0;
      O_BRAM_DIN  = I_DATA0;
    end else if (gnt1) begin
      O_BRAM_WE   = I_WE1;
      O_BRAM_ADDR = I_ADDR1;
      O_BRAM_DIN  = I_DATA1;
    end
  end

  // Next state, lock length and round-robin history.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    rr_last_d  = rr_last_q;
    if (gnt_any) rr_last_d = gnt0;
    case (state_q)
      ST_ARB: begin
        if (gnt1 && I_LOCK1) begin
          lock_cnt_d = LOCK_ONE;
          state_d    = (LOCK_MAX == LOCK_ONE) ? ST_YIELD : ST_LOCK1;
        end
      end
      ST_LOCK1: begin
        // Releasing the lock takes precedence over reaching the bound.
        if (!I_LOCK1) begin
          state_d    = ST_ARB;
          lock_cnt_d = '0;
        end else if (gnt1) begin
          lock_cnt_d = lock_inc;
          if (lock_inc == LOCK_MAX) state_d = ST_YIELD;
        end
      end
      default: begin
        state_d    = ST_ARB;
        lock_cnt_d = '0;
      end
    endcase
  end

  // State, counter and round-robin registers.
  always_ff @(posedge I_CLK or negedge I_RESET_L) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!I_RESET_L) begin
      state_q    <= ST_ARB;
      lock_cnt_q <= '0;
      rr_last_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      rr_last_q  <= rr_last_d;
    end
  end

  // Read tag: remembers which port owns the BRAM output next cycle.
  always_ff @(posedge I_CLK or negedge I_RESET_L) begin
    if (!I_RESET_L) begin
      tag_valid_q <= 1'b0;
      tag_port_q  <= PORT_CPU;
    end else begin
      tag_valid_q <= gnt_any & ~O_BRAM_WE;
      tag_port_q  <= gnt1 ? PORT_DMA : PORT_CPU;
    end
  end

  assign O_RVALID0 = tag_valid_q && (tag_port_q == PORT_CPU);
  assign O_RVALID1 = tag_valid_q && (tag_port_q == PORT_DMA);

  // Hold registers keep the last read result per port.
  always_ff @(posedge I_CLK or negedge I_RESET_L) begin
    // NOTE: the hold registers are plain flops, not a memory, so they take the async reset.
    if (!I_RESET_L) begin
      hold0_q <= '0;
      hold1_q <= '0;
    end else begin
      if (O_RVALID0) hold0_q <= I_BRAM_DOUT;
      if (O_RVALID1) hold1_q <= I_BRAM_DOUT;
    end
  end

  assign O_DATA0 = O_RVALID0 ? I_BRAM_DOUT : hold0_q;
  assign O_DATA1 = O_RVALID1 ? I_BRAM_DOUT : hold1_q;

endmodule

// File: tb/tb_bram_arbiter.sv
// Self-checking bench for bram_arbiter: behavioural model of the arbitration
// rules plus a BRAM model, directed scenarios with literal expectations, then
// randomized traffic. Build option BRAM_ARB_RR_EN selects the expected policy.
module tb_bram_arbiter;

  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 8;
  localparam int MAX_LOCK = 4;

  typedef struct {
    bit          rst;
    bit          r0, w0;
    logic [15:0] a0;
    logic [7:0]  d0;
    bit          r1, w1;
    logic [15:0] a1;
    logic [7:0]  d1;
    bit          lk;
  } stim_t;

  logic              I_CLK = 1'b0;
  logic              I_RESET_L = 1'b0;
  logic              I_REQ0 = 1'b0, I_REQ1 = 1'b0, I_WE0 = 1'b0, I_WE1 = 1'b0, I_LOCK1 = 1'b0;
  logic [ADDR_W-1:0] I_ADDR0 = '0, I_ADDR1 = '0;
  logic [DATA_W-1:0] I_DATA0 = '0, I_DATA1 = '0, I_BRAM_DOUT = '0;
  logic              O_ACK0, O_ACK1, O_RVALID0, O_RVALID1, O_BRAM_EN, O_BRAM_WE;
  logic [DATA_W-1:0] O_DATA0, O_DATA1, O_BRAM_DIN;
  logic [ADDR_W-1:0] O_BRAM_ADDR;

  always #5 I_CLK = ~I_CLK;

  bram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LOCK(MAX_LOCK)) dut (
    .I_CLK(I_CLK), .I_RESET_L(I_RESET_L),
    .I_REQ0(I_REQ0), .I_REQ1(I_REQ1), .I_WE0(I_WE0), .I_WE1(I_WE1),
    .I_ADDR0(I_ADDR0), .I_ADDR1(I_ADDR1), .I_DATA0(I_DATA0), .I_DATA1(I_DATA1),
    .I_LOCK1(I_LOCK1),
    .O_ACK0(O_ACK0), .O_ACK1(O_ACK1), .O_RVALID0(O_RVALID0), .O_RVALID1(O_RVALID1),
    .O_DATA0(O_DATA0), .O_DATA1(O_DATA1),
    .O_BRAM_EN(O_BRAM_EN), .O_BRAM_WE(O_BRAM_WE), .O_BRAM_ADDR(O_BRAM_ADDR),
    .O_BRAM_DIN(O_BRAM_DIN), .I_BRAM_DOUT(I_BRAM_DOUT)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // BRAM contents and next read output, updated from the DUT's BRAM pins.
  logic [7:0] bram [0:65535];
  logic [7:0] dout_next = 8'h00;

  // Behavioural model: who owns the BRAM and what is owed to each requester.
  bit         m_locked, m_yield, m_cpu_last;
  int         m_cnt;
  logic [7:0] m_hold [2];
  bit         pend_valid, pend_port;
  logic [7:0] pend_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_yield = 0; m_cnt = 0; m_cpu_last = 1;
    m_hold[0] = '0; m_hold[1] = '0;
    pend_valid = 0; pend_port = 0; pend_data = '0;
  endtask

  function automatic stim_t mk(bit r0, bit w0, logic [15:0] a0, logic [7:0] d0,
                               bit r1, bit w1, logic [15:0] a1, logic [7:0] d1,
                               bit lk, bit rst = 1'b1);
    stim_t s;
    s.rst = rst; s.r0 = r0; s.w0 = w0; s.a0 = a0; s.d0 = d0;
    s.r1 = r1; s.w1 = w1; s.a1 = a1; s.d1 = d1; s.lk = lk;
    return s;
  endfunction

  function automatic stim_t idle(bit rst = 1'b1);
    return mk(0, 0, 16'h0, 8'h0, 0, 0, 16'h0, 8'h0, 0, rst);
  endfunction

  // One clock cycle: drive, predict, compare, then advance model and BRAM.
  task automatic step(input stim_t s);
    bit          eg0, eg1, exp_en, exp_we, erv0, erv1;
    logic [15:0] exp_addr;
    logic [7:0]  exp_din, ed0, ed1;
    @(posedge I_CLK);
    #1;
    I_RESET_L = s.rst; I_LOCK1 = s.lk; I_BRAM_DOUT = dout_next;
    I_REQ0 = s.r0; I_WE0 = s.w0; I_ADDR0 = s.a0; I_DATA0 = s.d0;
    I_REQ1 = s.r1; I_WE1 = s.w1; I_ADDR1 = s.a1; I_DATA1 = s.d1;
    if (!s.rst) model_reset();

    eg0 = 0; eg1 = 0;
    if (s.rst) begin
      if (m_yield) eg0 = s.r0;
      else if (m_locked) eg1 = s.r1;
      else if (s.r0 && s.r1) begin
`ifdef BRAM_ARB_RR_EN
        eg1 = m_cpu_last;
        eg0 = !m_cpu_last;
`else
        eg0 = 1;
`endif
      end else begin
        eg0 = s.r0; eg1 = s.r1;
      end
    end
    exp_en   = eg0 | eg1;
    exp_we   = eg0 ? s.w0 : (eg1 ? s.w1 : 1'b0);
    exp_addr = eg0 ? s.a0 : (eg1 ? s.a1 : 16'h0);
    exp_din  = eg0 ? s.d0 : (eg1 ? s.d1 : 8'h0);
    erv0 = pend_valid && !pend_port;
    erv1 = pend_valid && pend_port;
    ed0  = erv0 ? pend_data : m_hold[0];
    ed1  = erv1 ? pend_data : m_hold[1];

    @(negedge I_CLK);
    check("ack0",      32'(O_ACK0),      32'(eg0));
    check("ack1",      32'(O_ACK1),      32'(eg1));
    check("bram_en",   32'(O_BRAM_EN),   32'(exp_en));
    check("bram_we",   32'(O_BRAM_WE),   32'(exp_we));
    check("bram_addr", 32'(O_BRAM_ADDR), 32'(exp_addr));
    check("bram_din",  32'(O_BRAM_DIN),  32'(exp_din));
    check("rvalid0",   32'(O_RVALID0),   32'(erv0));
    check("rvalid1",   32'(O_RVALID1),   32'(erv1));
    check("data0",     32'(O_DATA0),     32'(ed0));
    check("data1",     32'(O_DATA1),     32'(ed1));

    if (s.rst) begin
      if (erv0) m_hold[0] = pend_data;
      if (erv1) m_hold[1] = pend_data;
      pend_valid = exp_en && !exp_we;
      pend_port  = eg1;
      if (pend_valid) pend_data = bram[exp_addr];
      if (exp_en) m_cpu_last = eg0;
      if (m_yield) begin
        m_yield = 0; m_cnt = 0;
      end else if (m_locked) begin
        if (!s.lk) begin
          m_locked = 0; m_cnt = 0;
        end else if (eg1) begin
          m_cnt = (m_cnt + 1 > MAX_LOCK) ? MAX_LOCK : m_cnt + 1;
          if (m_cnt == MAX_LOCK) begin m_locked = 0; m_yield = 1; end
        end
      end else if (eg1 && s.lk) begin
        m_cnt = 1;
        if (MAX_LOCK == 1) m_yield = 1; else m_locked = 1;
      end
    end

    if (O_BRAM_EN && !O_BRAM_WE) dout_next = bram[O_BRAM_ADDR];
    if (O_BRAM_EN && O_BRAM_WE) bram[O_BRAM_ADDR] = O_BRAM_DIN;
  endtask

  task automatic do_reset();
    step(idle(1'b0));
    step(idle(1'b1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit [3:0] seq0, seq1;
    bit [6:0] lk0, lk1;
    bit       lk_state;
    int       rst_left;
    stim_t    s;

    for (int i = 0; i < 65536; i++) bram[i] = 8'($urandom);
    bram[16'h8000] = 8'h5A;
    model_reset();

    // Reset and idle.
    step(idle(1'b0));
    step(idle(1'b0));
    check("rst_bram_en", 32'(O_BRAM_EN), 32'h0);
    step(idle());
    step(idle());
    check("idle_data0", 32'(O_DATA0), 32'h0);
    check("idle_rvalid1", 32'(O_RVALID1), 32'h0);

    // Single read of 0x8000 holding 0x5A.
    step(mk(1, 0, 16'h8000, 8'h0, 0, 0, 16'h0, 8'h0, 0));
    check("rd_ack0", 32'(O_ACK0), 32'h1);
    check("rd_addr", 32'(O_BRAM_ADDR), 32'h8000);
    step(idle());
    check("rd_rvalid0", 32'(O_RVALID0), 32'h1);
    check("rd_data0", 32'(O_DATA0), 32'h5A);
    step(idle());
    check("rd_hold_valid", 32'(O_RVALID0), 32'h0);
    check("rd_hold_data", 32'(O_DATA0), 32'h5A);

    // Reset asserted while a read result is in flight.
    step(mk(1, 0, 16'h8000, 8'h0, 0, 0, 16'h0, 8'h0, 0));
    step(mk(1, 0, 16'h1234, 8'h0, 1, 0, 16'h4321, 8'h0, 1, 1'b0));
    check("mid_rst_rvalid0", 32'(O_RVALID0), 32'h0);
    check("mid_rst_data0", 32'(O_DATA0), 32'h0);
    check("mid_rst_en", 32'(O_BRAM_EN), 32'h0);
    check("mid_rst_ack0", 32'(O_ACK0), 32'h0);
    step(idle());
    step(idle());
    check("post_rst_data0", 32'(O_DATA0), 32'h0);

    // Contention for four cycles straight after reset.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(mk(1, 0, 16'(16'h0100 + i), 8'h0, 1, 0, 16'(16'h0200 + i), 8'h0, 0));
      seq0[i] = O_ACK0;
      seq1[i] = O_ACK1;
    end
`ifdef BRAM_ARB_RR_EN
    check("contend_ack1_seq", 32'(seq1), 32'b0101);
    check("contend_ack0_seq", 32'(seq0), 32'b1010);
`else
    check("contend_ack0_seq", 32'(seq0), 32'b1111);
    check("contend_ack1_seq", 32'(seq1), 32'b0000);
`endif
    step(idle());

    // Port 1 writes 0xC3 to 0xFE10, then port 0 reads it back.
    step(mk(0, 0, 16'h0, 8'h0, 1, 1, 16'hFE10, 8'hC3, 0));
    check("wr_we", 32'(O_BRAM_WE), 32'h1);
    check("wr_ack1", 32'(O_ACK1), 32'h1);
    step(mk(1, 0, 16'hFE10, 8'h0, 0, 0, 16'h0, 8'h0, 0));
    check("rb_we", 32'(O_BRAM_WE), 32'h0);
    step(idle());
    check("rb_rvalid0", 32'(O_RVALID0), 32'h1);
    check("rb_data0", 32'(O_DATA0), 32'hC3);

    // Lock bound: four DMA grants, one forced CPU slot, then relock.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(mk((i != 0 && i != 5), 0, 16'h0300, 8'h0, 1, 0, 16'(16'h0400 + i), 8'h0, 1));
      lk0[i] = O_ACK0;
      lk1[i] = O_ACK1;
    end
    check("lock_ack1_seq", 32'(lk1), 32'b1101111);
    check("lock_ack0_seq", 32'(lk0), 32'b0010000);
    step(idle());
    step(idle());

    // Lock release: two locked grants, drop the lock, CPU gets the next cycle.
    do_reset();
    step(mk(0, 0, 16'h0, 8'h0, 1, 0, 16'h0500, 8'h0, 1));
    check("rel_ack1_a", 32'(O_ACK1), 32'h1);
    step(mk(1, 0, 16'h0600, 8'h0, 1, 0, 16'h0501, 8'h0, 1));
    check("rel_ack1_b", 32'(O_ACK1), 32'h1);
    check("rel_blocked0", 32'(O_ACK0), 32'h0);
    step(mk(1, 0, 16'h0600, 8'h0, 0, 0, 16'h0, 8'h0, 0));
    check("rel_drop_ack0", 32'(O_ACK0), 32'h0);
    step(mk(1, 0, 16'h0600, 8'h0, 0, 0, 16'h0, 8'h0, 0));
    check("rel_next_ack0", 32'(O_ACK0), 32'h1);
    step(idle());

    // Randomized traffic over a small address window with occasional resets.
    lk_state = 0;
    rst_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (rst_left == 0 && $urandom_range(0, 299) == 0) rst_left = 1 + $urandom_range(0, 1);
      if ($urandom_range(0, 7) == 0) lk_state = ~lk_state;
      s = mk($urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0,
             16'(16'hFE10 + $urandom_range(0, 15)), 8'($urandom),
             $urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0,
             16'(16'hFE10 + $urandom_range(0, 15)), 8'($urandom),
             lk_state, rst_left == 0);
      if (rst_left > 0) rst_left--;
      step(s);
    end
    step(idle());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
